// File: rtl/ycbcr_skin_bbox_pkg.sv
// Shared constants for the skin classifier / bounding-box block:
// default chroma window, coordinate widths and frame FSM encodings.
package skin_pkg;

    localparam int X_W   = 11;
    localparam int Y_W   = 10;
    localparam int CNT_W = 20;

    localparam logic [7:0] CB_MIN_DEF  = 8'd77;
    localparam logic [7:0] CB_MAX_DEF  = 8'd127;
    localparam logic [7:0] CR_MIN_DEF  = 8'd133;
    localparam logic [7:0] CR_MAX_DEF  = 8'd173;
    localparam int         MIN_PIX_DEF = 64;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_LATCH  = 2'd2;

    function automatic logic in_win(input logic [7:0] v, input logic [7:0] lo,
                                    input logic [7:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/ycbcr_skin_bbox_if.sv
// Pixel stream in/out plus latched bounding-box results of the skin detector.
interface ycbcr_skin_bbox_if;
    import skin_pkg::*;

    logic             per_frame_vsync;
    logic             per_frame_href;
    logic             per_frame_clken;
    logic [7:0]       per_img_Y;
    logic [7:0]       per_img_Cb;
    logic [7:0]       per_img_Cr;

    logic             post_frame_vsync;
    logic             post_frame_href;
    logic             post_frame_clken;
    logic [7:0]       post_img_bit;

    logic [X_W-1:0]   box_x_min;
    logic [X_W-1:0]   box_x_max;
    logic [Y_W-1:0]   box_y_min;
    logic [Y_W-1:0]   box_y_max;
    logic [CNT_W-1:0] box_count;
    logic             box_valid;
    logic             box_update;

    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken,
               per_img_Y, per_img_Cb, per_img_Cr,
        input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit,
               box_x_min, box_x_max, box_y_min, box_y_max,
               box_count, box_valid, box_update
    );

    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken,
               per_img_Y, per_img_Cb, per_img_Cr,
        output post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit,
               box_x_min, box_x_max, box_y_min, box_y_max,
               box_count, box_valid, box_update
    );

endinterface

// File: rtl/ycbcr_skin_bbox_accum.sv
// Running min/max/count of skin pixel coordinates, with a frame-end latch
// into the externally visible box registers.
module bbox_accum
    import skin_pkg::*;
#(
    parameter int MIN_PIX = MIN_PIX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init_i,
    input  logic             upd_i,
    input  logic             latch_i,
    input  logic [X_W-1:0]   x_i,
    input  logic [Y_W-1:0]   y_i,
    output logic [X_W-1:0]   box_x_min_o,
    output logic [X_W-1:0]   box_x_max_o,
    output logic [Y_W-1:0]   box_y_min_o,
    output logic [Y_W-1:0]   box_y_max_o,
    output logic [CNT_W-1:0] box_count_o,
    output logic             box_valid_o
);

    logic [X_W-1:0]   xmin_q, xmin_d, xmax_q, xmax_d;
    logic [Y_W-1:0]   ymin_q, ymin_d, ymax_q, ymax_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             has_pix;

    assign has_pix = (cnt_q != '0);

    always_comb begin
        xmin_d = xmin_q;
        xmax_d = xmax_q;
        ymin_d = ymin_q;
        ymax_d = ymax_q;
        cnt_d  = cnt_q;
        if (init_i) begin
            xmin_d = '1;
            xmax_d = '0;
            ymin_d = '1;
            ymax_d = '0;
            cnt_d  = '0;
        end else if (upd_i) begin
            if (x_i < xmin_q) xmin_d = x_i;
            if (x_i > xmax_q) xmax_d = x_i;
            if (y_i < ymin_q) ymin_d = y_i;
            if (y_i > ymax_q) ymax_d = y_i;
            if (cnt_q != '1)  cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xmin_q      <= '1;
            xmax_q      <= '0;
            ymin_q      <= '1;
            ymax_q      <= '0;
            cnt_q       <= '0;
            box_x_min_o <= '0;
            box_x_max_o <= '0;
            box_y_min_o <= '0;
            box_y_max_o <= '0;
            box_count_o <= '0;
            box_valid_o <= 1'b0;
        end else begin
            xmin_q <= xmin_d;
            xmax_q <= xmax_d;
            ymin_q <= ymin_d;
            ymax_q <= ymax_d;
            cnt_q  <= cnt_d;
            // Empty frame reports a zero box instead of the inverted init values.
            if (latch_i) begin
                box_x_min_o <= has_pix ? xmin_q : '0;
                box_x_max_o <= has_pix ? xmax_q : '0;
                box_y_min_o <= has_pix ? ymin_q : '0;
                box_y_max_o <= has_pix ? ymax_q : '0;
                box_count_o <= cnt_q;
                box_valid_o <= (cnt_q >= CNT_W'(MIN_PIX));
            end
        end
    end

endmodule

// File: rtl/ycbcr_skin_bbox.sv
// Cb/Cr window skin classifier: 2-cycle binary pixel stream plus a per-frame
// bounding box of skin pixels, latched once the last pixel has been counted.
module ycbcr_skin_bbox
    import skin_pkg::*;
#(
    parameter logic [7:0] CB_MIN  = CB_MIN_DEF,
    parameter logic [7:0] CB_MAX  = CB_MAX_DEF,
    parameter logic [7:0] CR_MIN  = CR_MIN_DEF,
    parameter logic [7:0] CR_MAX  = CR_MAX_DEF,
    parameter int         MIN_PIX = MIN_PIX_DEF
) (
    input logic              clk,
    input logic              rst,
    ycbcr_skin_bbox_if.slave px
);

    logic [2:0]      sync_in;
    logic [1:0][2:0] sync_pipe_q;
    logic            vs_prev_q, href_prev_q;
    logic            vs_rise, vs_d1_fall, href_fall;
    logic [X_W-1:0]  x_cnt_q, x_cnt_d, x_q;
    logic [Y_W-1:0]  y_cnt_q, y_cnt_d, y_q;
    logic            skin_d, skin_q, q_q;
    logic [7:0]      img_q;
    logic [1:0]      state_q, state_d;
    logic            arm_pend_q, arm_pend_d;
    logic            box_update_q;
    logic            frame_armed, acc_init, acc_upd, acc_latch;

    assign sync_in    = {px.per_frame_vsync, px.per_frame_href, px.per_frame_clken};
    assign vs_rise    = px.per_frame_vsync & ~vs_prev_q;
    assign href_fall  = ~px.per_frame_href & href_prev_q;
    assign vs_d1_fall = ~sync_pipe_q[0][2] & sync_pipe_q[1][2];
    assign skin_d     = in_win(px.per_img_Cb, CB_MIN, CB_MAX) &&
                        in_win(px.per_img_Cr, CR_MIN, CR_MAX);

    always_comb begin
        x_cnt_d = x_cnt_q;
        if (!px.per_frame_href)
            x_cnt_d = '0;
        else if (px.per_frame_clken && x_cnt_q != '1)
            x_cnt_d = x_cnt_q + 1'b1;
    end

    always_comb begin
        y_cnt_d = y_cnt_q;
        if (vs_rise)
            y_cnt_d = '0;
        else if (href_fall && y_cnt_q != '1)
            y_cnt_d = y_cnt_q + 1'b1;
    end

    // A vsync rise can coincide with the delayed fall of the previous frame;
    // remember it so the new frame still arms after the latch cycle.
    always_comb begin
        state_d    = state_q;
        arm_pend_d = arm_pend_q;
        case (state_q)
            ST_IDLE:   if (vs_rise) state_d = ST_ACTIVE;
            ST_ACTIVE: begin
                if (vs_d1_fall) state_d = ST_LATCH;
                if (vs_rise)    arm_pend_d = 1'b1;
            end
            ST_LATCH: begin
                state_d    = (arm_pend_q || vs_rise) ? ST_ACTIVE : ST_IDLE;
                arm_pend_d = 1'b0;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    assign frame_armed = (state_q == ST_ACTIVE);
    assign acc_latch   = (state_q == ST_LATCH);
    assign acc_init    = acc_latch || (state_q == ST_IDLE && vs_rise);
    assign acc_upd     = frame_armed && q_q && skin_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_pipe_q  <= '0;
            vs_prev_q    <= 1'b1;  // no false rise when reset lands mid-frame
            href_prev_q  <= 1'b0;
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            skin_q       <= 1'b0;
            q_q          <= 1'b0;
            img_q        <= '0;
            state_q      <= ST_IDLE;
            arm_pend_q   <= 1'b0;
            box_update_q <= 1'b0;
        end else begin
            sync_pipe_q  <= {sync_pipe_q[0], sync_in};
            vs_prev_q    <= px.per_frame_vsync;
            href_prev_q  <= px.per_frame_href;
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            x_q          <= x_cnt_q;
            y_q          <= y_cnt_q;
            skin_q       <= skin_d;
            q_q          <= px.per_frame_href & px.per_frame_clken;
            img_q        <= (skin_q && sync_pipe_q[0][1]) ? 8'hFF : 8'h00;
            state_q      <= state_d;
            arm_pend_q   <= arm_pend_d;
            box_update_q <= acc_latch;
        end
    end

    bbox_accum #(.MIN_PIX(MIN_PIX)) u_accum (
        .clk         (clk),
        .rst         (rst),
        .init_i      (acc_init),
        .upd_i       (acc_upd),
        .latch_i     (acc_latch),
        .x_i         (x_q),
        .y_i         (y_q),
        .box_x_min_o (px.box_x_min),
        .box_x_max_o (px.box_x_max),
        .box_y_min_o (px.box_y_min),
        .box_y_max_o (px.box_y_max),
        .box_count_o (px.box_count),
        .box_valid_o (px.box_valid)
    );

    assign px.post_frame_vsync = sync_pipe_q[1][2];
    assign px.post_frame_href  = sync_pipe_q[1][1];
    assign px.post_frame_clken = sync_pipe_q[1][0];
    assign px.post_img_bit     = img_q;
    assign px.box_update       = box_update_q;

endmodule

// File: tb/tb_ycbcr_skin_bbox.sv
// Directed frames against a pixel scoreboard (2-cycle latency) and a box
// scoreboard filled from the bench's own raster model.
module tb_ycbcr_skin_bbox;
    import skin_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ycbcr_skin_bbox_if px();

    ycbcr_skin_bbox dut (
        .clk (clk),
        .rst (rst),
        .px  (px)
    );

    typedef struct {
        logic [2:0] sync;
        logic [7:0] img;
        bit         zero;
    } pix_t;

    typedef struct {
        int xmin, xmax, ymin, ymax, cnt, valid;
    } box_t;

    pix_t pq[$];
    box_t bq[$];
    pix_t me;
    box_t mb;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit is_skin(input int cb, input int cr);
        return (cb >= 77) && (cb <= 127) && (cr >= 133) && (cr <= 173);
    endfunction

    function automatic bit skin_at(input int mode, input int x, input int y);
        case (mode)
            0:       return (x == 3 && y == 2) || (x == 10 && y == 5) || (x == 7 && y == 6);
            1:       return 1'b1;
            2:       return 1'b0;
            default: return ((x * 7 + y * 3) % 5) == 0;
        endcase
    endfunction

    task automatic pick(input bit sk, input int k, output int cb, output int cr);
        if (sk) begin
            case (k % 3)
                0:       begin cb = 77;  cr = 133; end
                1:       begin cb = 127; cr = 173; end
                default: begin cb = 100; cr = 150; end
            endcase
        end else begin
            case (k % 4)
                0:       begin cb = 76;  cr = 133; end
                1:       begin cb = 128; cr = 173; end
                2:       begin cb = 100; cr = 132; end
                default: begin cb = 100; cr = 174; end
            endcase
        end
    endtask

    // One clock of stimulus; a reset cycle forces the previous and current
    // scoreboard entries to zero because both are still in the pipe.
    task automatic step(input bit vs, input bit hr, input bit ce,
                        input int cb, input int cr, input bit r);
        pix_t e, t;
        rst                = r;
        px.per_frame_vsync = vs;
        px.per_frame_href  = hr;
        px.per_frame_clken = ce;
        px.per_img_Y       = 8'($urandom);
        px.per_img_Cb      = 8'(cb);
        px.per_img_Cr      = 8'(cr);
        if (r && pq.size() > 0) begin
            t = pq.pop_back();
            t.zero = 1'b1;
            pq.push_back(t);
        end
        e.sync = {vs, hr, ce};
        e.img  = (hr && is_skin(cb, cr)) ? 8'd255 : 8'd0;
        e.zero = r;
        pq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input int w, input int h, input int mode, input bit tog,
                         input int vlow, input int rst_row);
        box_t b;
        int   cb, cr;
        bit   sk;
        b.xmin = 1 << 30; b.xmax = 0; b.ymin = 1 << 30; b.ymax = 0; b.cnt = 0;
        step(1, 0, 0, 60, 60, 0);
        step(1, 0, 0, 60, 60, 0);
        for (int y = 0; y < h; y++) begin
            if (y == rst_row) begin
                repeat (3) step(1, 0, 0, 100, 150, 1);
                chk("rst_box_x_max", px.box_x_max, 0);
                chk("rst_box_y_max", px.box_y_max, 0);
                chk("rst_box_count", px.box_count, 0);
                chk("rst_box_valid", px.box_valid, 0);
                chk("rst_post_href", px.post_frame_href, 0);
            end
            for (int x = 0; x < w; x++) begin
                sk = skin_at(mode, x, y);
                pick(sk, x + y, cb, cr);
                step(1, 1, 1, cb, cr, 0);
                if (sk) begin
                    b.cnt++;
                    if (x < b.xmin) b.xmin = x;
                    if (x > b.xmax) b.xmax = x;
                    if (y < b.ymin) b.ymin = y;
                    if (y > b.ymax) b.ymax = y;
                end
                if (tog) step(1, 1, 0, 100, 150, 0);
            end
            repeat (3) step(1, 0, 0, 60, 60, 0);
        end
        if (rst_row < 0) begin
            if (b.cnt == 0) begin
                b.xmin = 0; b.xmax = 0; b.ymin = 0; b.ymax = 0;
            end
            b.valid = (b.cnt >= 64) ? 1 : 0;
            bq.push_back(b);
        end
        repeat (vlow) step(0, 0, 0, 60, 60, 0);
    endtask

    always @(negedge clk) begin
        if (pq.size() >= 3) begin
            me = pq.pop_front();
            chk("post_sync", {px.post_frame_vsync, px.post_frame_href, px.post_frame_clken},
                me.zero ? 3'b000 : me.sync);
            chk("post_img_bit", px.post_img_bit, me.zero ? 8'd0 : me.img);
        end
        if (px.box_update === 1'b1) begin
            if (bq.size() == 0) begin
                chk("unexpected_box_update", px.box_update, 0);
            end else begin
                mb = bq.pop_front();
                chk("box_x_min", px.box_x_min, mb.xmin);
                chk("box_x_max", px.box_x_max, mb.xmax);
                chk("box_y_min", px.box_y_min, mb.ymin);
                chk("box_y_max", px.box_y_max, mb.ymax);
                chk("box_count", px.box_count, mb.cnt);
                chk("box_valid", px.box_valid, mb.valid);
            end
        end
    end

    initial begin
        step(0, 0, 0, 60, 60, 1);
        step(0, 0, 0, 60, 60, 1);
        chk("reset_box_x_min", px.box_x_min, 0);
        chk("reset_box_count", px.box_count, 0);
        chk("reset_box_valid", px.box_valid, 0);
        chk("reset_box_update", px.box_update, 0);
        chk("reset_post_img", px.post_img_bit, 0);
        step(0, 0, 0, 60, 60, 0);

        // threshold edges on a line outside any frame
        step(0, 1, 1, 77, 133, 0);
        step(0, 1, 1, 76, 133, 0);
        step(0, 1, 1, 100, 174, 0);
        step(0, 1, 1, 127, 173, 0);
        step(0, 0, 0, 100, 150, 0);
        repeat (3) step(0, 0, 0, 60, 60, 0);

        frame(16, 8, 0, 0, 4, -1);   // sparse: box 3..10 x 2..6, count 3
        frame(16, 8, 1, 0, 4, -1);   // full skin: count 128, valid
        frame(16, 8, 2, 0, 4, -1);   // no skin: zero box
        frame(16, 8, 0, 1, 4, -1);   // clken toggling, disabled cycles carry skin
        frame(16, 8, 3, 0, 1, -1);   // vsync rises right after frame end
        frame(16, 8, 0, 0, 4, -1);
        frame(16, 8, 1, 0, 4, 3);    // reset mid-frame: no update expected
        frame(16, 8, 1, 0, 4, -1);

        repeat (10) step(0, 0, 0, 60, 60, 0);
        chk("box_updates_pending", bq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ycbcr_skin_bbox.md
Name: ycbcr_skin_bbox

Overview:
- Downstream consumer of the RGB888-to-YCbCr stage. Classifies each pixel as skin or non-skin using Cb/Cr window thresholds.
- Emits a binary image stream (0/255) with re-aligned sync signals.
- Accumulates a per-frame bounding box and pixel count of skin pixels, latched at frame end, for the overlay/tracking logic.

Parameters:
- CB_MIN, 77, inclusive lower Cb bound
- CB_MAX, 127, inclusive upper Cb bound
- CR_MIN, 133, inclusive lower Cr bound
- CR_MAX, 173, inclusive upper Cr bound
- X_W, 11, column coordinate width
- Y_W, 10, row coordinate width
- CNT_W, 20, skin pixel counter width
- MIN_PIX, 64, minimum skin pixels for box_valid

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset (one clock; reset is synchronous and active-high)
- per_frame_vsync  in  1  frame valid, high during frame
- per_frame_href  in  1  line valid
- per_frame_clken  in  1  pixel enable
- per_img_Y  in  8  luma (pass-through unused by classifier)
- per_img_Cb  in  8  blue chroma
- per_img_Cr  in  8  red chroma
- post_frame_vsync  out  1  vsync delayed 2
- post_frame_href  out  1  href delayed 2
- post_frame_clken  out  1  clken delayed 2
- post_img_bit  out  8  255 skin / 0 otherwise
- box_x_min, box_x_max  out  X_W  latched column bounds
- box_y_min, box_y_max  out  Y_W  latched row bounds
- box_count  out  CNT_W  latched skin pixel count
- box_valid  out  1  latched count >= MIN_PIX
- box_update  out  1  one-cycle pulse when box_* latched

Behaviour:
- Reset: all outputs 0; accumulators at init; frame_armed=0.
- Pixel path, latency 2:
  - Stage 1 registers skin = (CB_MIN<=Cb<=CB_MAX) && (CR_MIN<=Cr<=CR_MAX), plus x_cnt/y_cnt and the qualifier q = href&clken.
  - Stage 2 registers the output byte.
  - post_img_bit = post_frame_href ? (skin?8'd255:8'd0) : 8'd0.
  - Sync signals pass through a 2-deep shift register. Comparisons are unsigned, bounds inclusive.
- Coordinates:
  - x_cnt increments on each per_frame_clken&&per_frame_href and clears when href is low. Saturates at all-ones.
  - y_cnt increments on each href falling edge and clears on vsync rising edge. Saturates at all-ones.
  - The first pixel of a frame is (0,0).
- Accumulation (stage 1 outputs, only when frame_armed && q_d1 && skin_d1):
  - acc_x_min=min(acc_x_min,x); acc_x_max=max(acc_x_max,x); same for y.
  - acc_cnt increments, saturating at all-ones.
  - Init values: x/y_min all-ones, x/y_max 0, cnt 0.
- Frame FSM: IDLE -> ACTIVE on vsync rising edge (sets frame_armed, reinits accumulators) -> LATCH on falling edge of vsync delayed 1 (so the final pixel is included) -> IDLE.
- LATCH, one cycle:
  - box_* <= acc_*; box_valid <= (acc_cnt>=MIN_PIX).
  - If acc_cnt==0, box coordinates latch as 0.
  - box_update=1 for exactly one cycle; accumulators reinit; frame_armed cleared.
- box_* registers hold between updates.
- Reset mid-frame: frame_armed=0, so the partial frame produces no box_update. Accumulation resumes at the next vsync rising edge.
- Vsync rising edge in the same cycle as LATCH: the latch completes first; the new frame arms on the following cycle. Pixels cannot be lost because href is low around vsync.
- clken low within href: pixel ignored, x_cnt held.

Decomposition:
- Package skin_pkg: default threshold constants, X_W/Y_W/CNT_W, FSM state enum (IDLE, ACTIVE, LATCH).
- Sub-module bbox_accum: min/max/count registers with init/update/latch controls, instantiated once.

Test Plan:
- Reset check: assert rst 3 cycles mid-stream -> all outputs 0; no box_update until a full vsync high/low cycle completes after reset.
- Threshold edges: Cb=77,Cr=133 -> 255; Cb=76 -> 0; Cr=174 -> 0; Cb=127,Cr=173 -> 255. Each result appears exactly 2 cycles after input; post_img_bit=0 whenever post href is low.
- 16x8 frame, skin pixels at (3,2),(10,5),(7,6) -> box_update one cycle after delayed vsync fall with x_min=3, x_max=10, y_min=2, y_max=6, count=3, box_valid=0 (MIN_PIX=64).
- 16x8 fully skin frame with MIN_PIX=64 -> x 0..15, y 0..7, count=128, box_valid=1. Next frame all non-skin -> count=0, box coordinates 0, valid=0.
- clken toggling 1/0 within lines -> x coordinates count only enabled pixels. Sync outputs equal inputs delayed by exactly 2.
- Frame end immediately followed by vsync rise the next cycle -> single box_update for the old frame; new frame accumulates from reinitialised values.
